custom_ip_to_fifo_stream: RTL and testbench
===========================================

Name: custom_ip_to_fifo_stream

Overview:
- Successor to the combinational HLS-to-FIFO packer. Packs the HLS ap_fifo header fields and a parametrised number of 32-bit message words into one packet. Buffers up to two packets in a registered skid buffer, then writes them into a downstream FIFO whose width may be narrower than the packet, serialising into beats.
- Sits between a Vivado HLS custom IP (out_fifo_V_* ports) and the native FIFO write port. Provides registered full_n, a last-beat marker, a sticky overflow flag and a packet counter.

Parameters:
- PACKET_SIZE_BITS, 256, total packet width; must equal 64 + 32*MSG_WORDS (256, 512 and 1024 are the supported sizes).
- MSG_WORDS, (PACKET_SIZE_BITS-64)/32, derived local parameter: message word count (6, 14 or 30).
- FIFO_DATA_BITS, 256, downstream FIFO width; must divide PACKET_SIZE_BITS exactly.
- BEATS, PACKET_SIZE_BITS/FIFO_DATA_BITS, derived local parameter: beats per packet, at least 1.

Ports:
- ap_clk  in  1  clock; all logic is on the rising edge.
- ap_rst  in  1  reset; synchronous, active-high.
- out_fifo_V_BS_ID_din  in  8  header byte 0 (packet MSBs).
- out_fifo_V_BS_ID_write  in  1  HLS write strobe for the whole packet.
- out_fifo_V_FPGA_ID_din  in  8  header field.
- out_fifo_V_PCKG_ID_din  in  16  header field.
- out_fifo_V_TX_UID_din  in  8  header field.
- out_fifo_V_RX_UID_din  in  8  header field.
- out_fifo_V_VALID_PACKET_BYTES_din  in  16  header field.
- out_fifo_V_MESSAGE_din  in  32*MSG_WORDS  message words; MESSAGE_0 occupies the top 32 bits.
- full_n  out  1  registered ready signal to the HLS IP.
- full  in  1  downstream FIFO full.
- wr_en  out  1  downstream FIFO write enable.
- din  out  FIFO_DATA_BITS  downstream beat data.
- din_last  out  1  high on the final beat of a packet.
- overflow  out  1  sticky: a write was attempted while full_n was 0.
- pkt_count  out  32  number of packets fully written downstream; wraps modulo 2^32.

Behaviour:
- Packet layout, MSB to LSB: BS_ID, FPGA_ID, PCKG_ID, TX_UID, RX_UID, VALID_PACKET_BYTES, MESSAGE_0 through MESSAGE_{N-1}.
- Acceptance:
  - A packet is accepted when out_fifo_V_BS_ID_write is 1 and full_n is 1; all din fields are captured that cycle.
  - The 2-entry buffer has an occupancy count of 0 to 2.
  - full_n is a register equal to (next_count < 2).
- Overflow: a write while full_n is 0 is ignored (buffer unchanged) and sets overflow to 1. overflow clears only on reset.
- Output FSM:
  - States: IDLE and SEND. A beat counter runs from 0 to BEATS-1.
  - IDLE -> SEND when count > 0.
  - In SEND: wr_en = ~full; din = head packet slice [PACKET_SIZE_BITS-1-beat*FIFO_DATA_BITS -: FIFO_DATA_BITS], i.e. MSB slice first.
  - The beat counter advances only when wr_en is 1.
  - din_last = wr_en && (beat == BEATS-1).
  - On a last-beat write: pop the head, increment pkt_count, reset beat to 0. Stay in SEND if count after the pop is > 0, else go to IDLE.
- Backpressure: while full=1, wr_en=0; din, beat and head hold stable.
- wr_en, din and din_last are combinational from registered state and full. No combinational path from the HLS inputs to any output.
- Latency: a packet accepted at edge t gives the earliest wr_en in cycle t+1.
- Throughput: with BEATS=1 and full=0, one packet per cycle is sustained and full_n stays 1.
- Simultaneous push and pop at count=1: count stays 1 and ordering is preserved. Push at count=2 cannot occur because full_n=0.
- Reset, while ap_rst=1:
  - count=0, state=IDLE, beat=0.
  - full_n=0, wr_en=0, din=0, din_last=0, overflow=0, pkt_count=0.
  - full_n rises in the first cycle after ap_rst drops.
- Reset during SEND: the partial packet is discarded with no further beats; the downstream is responsible for handling the truncated packet.
- Parameter errors: an illegal PACKET_SIZE_BITS/FIFO_DATA_BITS combination triggers an elaboration-time $error.

Decomposition:
- Shared package custom_ip_fifo_pkg:
  - HDR_BITS=64 and MSG_WORD_BITS=32.
  - The header field offsets.
  - A function msg_words(packet_bits).
- One sub-module, pkt_skid_buffer_2: a 2-entry FIFO parametrised by width. It provides push/pop, head and count, and generates the registered full_n.
- The packer concatenation and the beat FSM stay in the top level.

Test Plan:
- Reset, then a single write with BS_ID=0xA5, MESSAGE_0=0x11111111, BEATS=1 -> wr_en in the next cycle, din[255:248]=0xA5, din_last=1, pkt_count=1.
- FIFO_DATA_BITS=64, PACKET_SIZE_BITS=256 -> 4 beats MSB-first; din_last only on beat 3; the header appears in beat 0.
- full=1 held for 10 cycles, then 3 back-to-back writes -> full_n drops after 2 accepted writes; 3rd write sets overflow=1; the 2 stored packets are output in order after full=0.
- Sustained writes with BEATS=1 and full=0 for 100 cycles -> 100 wr_en pulses, full_n stays 1, pkt_count=100.
- Assert ap_rst mid-packet (beat 2 of 4) -> outputs zero the next cycle; after release full_n=1 and pkt_count=0; a new packet starts at beat 0.
- pkt_count preloaded to 0xFFFFFFFF via force, then one packet -> pkt_count wraps to 0.

Source files
------------

// File: rtl/custom_ip_fifo_pkg.sv
// Shared definitions for the HLS ap_fifo to native FIFO packet streamer:
// header geometry, field offsets, output FSM encoding and parameter helpers.
package custom_ip_fifo_pkg;

    localparam int HDR_BITS      = 64;
    localparam int MSG_WORD_BITS = 32;

    // Header field widths
    localparam int BS_ID_BITS   = 8;
    localparam int FPGA_ID_BITS = 8;
    localparam int PCKG_ID_BITS = 16;
    localparam int TX_UID_BITS  = 8;
    localparam int RX_UID_BITS  = 8;
    localparam int VPB_BITS     = 16;

    // Header field LSB offsets inside the 64-bit header (BS_ID is the MSB byte)
    localparam int VPB_LSB     = 0;
    localparam int RX_UID_LSB  = VPB_LSB + VPB_BITS;
    localparam int TX_UID_LSB  = RX_UID_LSB + RX_UID_BITS;
    localparam int PCKG_ID_LSB = TX_UID_LSB + TX_UID_BITS;
    localparam int FPGA_ID_LSB = PCKG_ID_LSB + PCKG_ID_BITS;
    localparam int BS_ID_LSB   = FPGA_ID_LSB + FPGA_ID_BITS;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } send_state_e;

    // Number of 32-bit message words carried by a packet of the given width.
    function automatic int msg_words(input int packet_bits);
        return (packet_bits - HDR_BITS) / MSG_WORD_BITS;
    endfunction

    // Only the three packet sizes the HLS core can produce are supported.
    function automatic bit packet_size_legal(input int packet_bits);
        return (packet_bits == 256) || (packet_bits == 512) || (packet_bits == 1024);
    endfunction

    // The downstream width must split the packet into a whole number of beats.
    function automatic bit fifo_width_legal(input int packet_bits, input int fifo_bits);
        if (fifo_bits <= 0 || fifo_bits > packet_bits) begin
            return 1'b0;
        end
        return (packet_bits % fifo_bits) == 0;
    endfunction

endpackage

// File: rtl/pkt_skid_buffer_2.sv
// Two-entry packet FIFO. Pushes are only taken while full_n_o is high, so
// the registered full_n_o is the single source of truth for acceptance.
module pkt_skid_buffer_2
    import custom_ip_fifo_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o,
    output logic             full_n_o
);

    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       full_n_q, full_n_d;
    logic       push_ok;
    logic       pop_ok;

    // Qualify push/pop and compute next occupancy, pointers and ready.
    always_comb begin
        push_ok  = push_i && full_n_q;
        pop_ok   = pop_i && (count_q != 2'd0);
        count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        wr_ptr_d = wr_ptr_q ^ push_ok;
        rd_ptr_d = rd_ptr_q ^ pop_ok;
        full_n_d = (count_d < 2'd2);
    end

    // Control state; full_n stays low through reset and rises one cycle after.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            full_n_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_n_q <= full_n_d;
        end
    end

    // Payload storage: one register per slot, written when the write pointer selects it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_q;

            // Capture the incoming packet into this slot on an accepted push.
            always_ff @(posedge clk_i) begin
                if (push_ok && (wr_ptr_q == 1'(gi))) begin
                    entry_q <= data_i;
                end
            end
        end
    endgenerate

    assign head_o   = rd_ptr_q ? g_entry[1].entry_q : g_entry[0].entry_q;
    assign count_o  = count_q;
    assign full_n_o = full_n_q;

endmodule

// File: rtl/custom_ip_to_fifo_stream.sv
// Packs the HLS out_fifo_V header fields and message words into one packet,
// buffers up to two packets and serialises each into MSB-first beats for a
// downstream FIFO write port. Outputs depend only on registered state and full.
module custom_ip_to_fifo_stream
    import custom_ip_fifo_pkg::*;
#(
    parameter  int PACKET_SIZE_BITS = 256,
    parameter  int FIFO_DATA_BITS   = 256,
    localparam int MSG_WORDS        = msg_words(PACKET_SIZE_BITS),
    localparam int BEATS            = (FIFO_DATA_BITS > 0) ? (PACKET_SIZE_BITS / FIFO_DATA_BITS) : 1
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst,
    input  logic [BS_ID_BITS-1:0]              out_fifo_V_BS_ID_din,
    input  logic                               out_fifo_V_BS_ID_write,
    input  logic [FPGA_ID_BITS-1:0]            out_fifo_V_FPGA_ID_din,
    input  logic [PCKG_ID_BITS-1:0]            out_fifo_V_PCKG_ID_din,
    input  logic [TX_UID_BITS-1:0]             out_fifo_V_TX_UID_din,
    input  logic [RX_UID_BITS-1:0]             out_fifo_V_RX_UID_din,
    input  logic [VPB_BITS-1:0]                out_fifo_V_VALID_PACKET_BYTES_din,
    input  logic [MSG_WORD_BITS*MSG_WORDS-1:0] out_fifo_V_MESSAGE_din,
    output logic                               full_n,
    input  logic                               full,
    output logic                               wr_en,
    output logic [FIFO_DATA_BITS-1:0]          din,
    output logic                               din_last,
    output logic                               overflow,
    output logic [31:0]                        pkt_count
);

    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SLOTS  = 1 << BEAT_W;

    // Reject packet/FIFO width combinations the packer cannot serialise.
    generate
        if (!packet_size_legal(PACKET_SIZE_BITS) ||
            !fifo_width_legal(PACKET_SIZE_BITS, FIFO_DATA_BITS) ||
            (PACKET_SIZE_BITS != HDR_BITS + MSG_WORD_BITS * MSG_WORDS)) begin : g_param_check
            $error("custom_ip_to_fifo_stream: illegal PACKET_SIZE_BITS=%0d / FIFO_DATA_BITS=%0d",
                   PACKET_SIZE_BITS, FIFO_DATA_BITS);
        end
    endgenerate

    logic [HDR_BITS-1:0]         hdr;
    logic [PACKET_SIZE_BITS-1:0] pkt_in;
    logic [PACKET_SIZE_BITS-1:0] head;
    logic [1:0]                  count;
    logic                        buf_full_n;
    logic                        push_accept;
    logic                        pop;
    logic                        last_beat;
    logic [FIFO_DATA_BITS-1:0]   beat_slices [SLOTS];

    send_state_e       state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              overflow_q;
    logic [31:0]       pkt_count_q;

    // Assemble the header from the individual HLS fields, then append the message.
    always_comb begin
        hdr = '0;
        hdr[BS_ID_LSB   +: BS_ID_BITS]   = out_fifo_V_BS_ID_din;
        hdr[FPGA_ID_LSB +: FPGA_ID_BITS] = out_fifo_V_FPGA_ID_din;
        hdr[PCKG_ID_LSB +: PCKG_ID_BITS] = out_fifo_V_PCKG_ID_din;
        hdr[TX_UID_LSB  +: TX_UID_BITS]  = out_fifo_V_TX_UID_din;
        hdr[RX_UID_LSB  +: RX_UID_BITS]  = out_fifo_V_RX_UID_din;
        hdr[VPB_LSB     +: VPB_BITS]     = out_fifo_V_VALID_PACKET_BYTES_din;
        pkt_in = {hdr, out_fifo_V_MESSAGE_din};
    end

    pkt_skid_buffer_2 #(
        .WIDTH(PACKET_SIZE_BITS)
    ) u_skid (
        .clk_i   (ap_clk),
        .srst_i  (ap_rst),
        .push_i  (out_fifo_V_BS_ID_write),
        .data_i  (pkt_in),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count),
        .full_n_o(buf_full_n)
    );

    // Split the head packet into beats, beat 0 being the most significant slice.
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slice
            if (gi < BEATS) begin : g_used
                assign beat_slices[gi] = head[PACKET_SIZE_BITS-1-gi*FIFO_DATA_BITS -: FIFO_DATA_BITS];
            end else begin : g_pad
                assign beat_slices[gi] = '0;
            end
        end
    endgenerate

    assign last_beat   = (beat_q == BEAT_W'(BEATS - 1));
    assign push_accept = out_fifo_V_BS_ID_write && buf_full_n;

    // Beat FSM: drive the downstream write port and decide the next state/beat.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        wr_en    = 1'b0;
        din      = '0;
        din_last = 1'b0;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The buffer is empty here, so a packet appears only via a push.
                if (push_accept) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                wr_en = !full;
                din   = beat_slices[beat_q];
                if (wr_en) begin
                    if (last_beat) begin
                        din_last = 1'b1;
                        pop      = 1'b1;
                        beat_d   = '0;
                        // Keep sending if a packet remains after this pop.
                        if (!(count > 2'd1) && !push_accept) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM registers, sticky overflow and the completed-packet counter.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            overflow_q  <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (out_fifo_V_BS_ID_write && !buf_full_n) begin
                overflow_q <= 1'b1;
            end
            if (pop) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end
        end
    end

    assign full_n    = buf_full_n;
    assign overflow  = overflow_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_custom_ip_to_fifo_stream.sv
// Bench for custom_ip_to_fifo_stream: a single-beat (256/256) and a four-beat
// (256/64) instance share stimulus; a queue-of-beats model predicts outputs.
module tb_custom_ip_to_fifo_stream;

    logic         ap_clk = 1'b0;
    logic         ap_rst;
    logic         wr;
    logic [7:0]   bs, fpga, tx, rx;
    logic [15:0]  pckg, vpb;
    logic [191:0] msg;
    logic         full;

    logic         full_n1, wr_en1, last1, ovf1;
    logic [255:0] din1;
    logic [31:0]  cnt1;
    logic         full_n4, wr_en4, last4, ovf4;
    logic [63:0]  din4;
    logic [31:0]  cnt4;

    int checks = 0;
    int errors = 0;

    // Reference model state per instance (0: one beat, 1: four beats)
    logic [256:0] bq0[$];
    logic [256:0] bq1[$];
    int           occ [2];
    logic         m_full_n [2];
    logic         m_ovf [2];
    logic [31:0]  m_cnt [2];

    always #5 ap_clk = ~ap_clk;

    custom_ip_to_fifo_stream #(.PACKET_SIZE_BITS(256), .FIFO_DATA_BITS(256)) u_b1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .out_fifo_V_BS_ID_din(bs), .out_fifo_V_BS_ID_write(wr),
        .out_fifo_V_FPGA_ID_din(fpga), .out_fifo_V_PCKG_ID_din(pckg),
        .out_fifo_V_TX_UID_din(tx), .out_fifo_V_RX_UID_din(rx),
        .out_fifo_V_VALID_PACKET_BYTES_din(vpb), .out_fifo_V_MESSAGE_din(msg),
        .full_n(full_n1), .full(full), .wr_en(wr_en1), .din(din1),
        .din_last(last1), .overflow(ovf1), .pkt_count(cnt1)
    );

    custom_ip_to_fifo_stream #(.PACKET_SIZE_BITS(256), .FIFO_DATA_BITS(64)) u_b4 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .out_fifo_V_BS_ID_din(bs), .out_fifo_V_BS_ID_write(wr),
        .out_fifo_V_FPGA_ID_din(fpga), .out_fifo_V_PCKG_ID_din(pckg),
        .out_fifo_V_TX_UID_din(tx), .out_fifo_V_RX_UID_din(rx),
        .out_fifo_V_VALID_PACKET_BYTES_din(vpb), .out_fifo_V_MESSAGE_din(msg),
        .full_n(full_n4), .full(full), .wr_en(wr_en4), .din(din4),
        .din_last(last4), .overflow(ovf4), .pkt_count(cnt4)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] cur_pkt();
        return {bs, fpga, pckg, tx, rx, vpb, msg};
    endfunction

    function automatic logic [256:0] front(input int d);
        return (d == 0) ? bq0[0] : bq1[0];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            occ[d] = 0; m_full_n[d] = 1'b0; m_ovf[d] = 1'b0; m_cnt[d] = 32'd0;
        end
        bq0.delete();
        bq1.delete();
    endtask

    // Compare one instance against the model for this cycle, then advance the model.
    task automatic score(input int d, input logic wr_en_o, input logic [255:0] din_o,
                         input logic last_o, input logic fn_o, input logic ovf_o,
                         input logic [31:0] cnt_o);
        string        n;
        logic         exp_wr;
        logic [256:0] f;
        logic [255:0] pkt;
        n      = (d == 0) ? "b1" : "b4";
        exp_wr = (occ[d] > 0) && !full;
        chk({n, " full_n"}, 256'(fn_o), 256'(m_full_n[d]));
        chk({n, " wr_en"}, 256'(wr_en_o), 256'(exp_wr));
        chk({n, " overflow"}, 256'(ovf_o), 256'(m_ovf[d]));
        chk({n, " pkt_count"}, 256'(cnt_o), 256'(m_cnt[d]));
        if (exp_wr) begin
            f = front(d);
            chk({n, " din"}, din_o, f[255:0]);
            chk({n, " din_last"}, 256'(last_o), 256'(f[256]));
        end else if (occ[d] == 0) begin
            chk({n, " idle din"}, din_o, 256'd0);
            chk({n, " idle din_last"}, 256'(last_o), 256'd0);
        end
        if (ap_rst) begin
            occ[d] = 0; m_full_n[d] = 1'b0; m_ovf[d] = 1'b0; m_cnt[d] = 32'd0;
            if (d == 0) bq0.delete(); else bq1.delete();
        end else begin
            if (exp_wr) begin
                f = front(d);
                if (d == 0) void'(bq0.pop_front()); else void'(bq1.pop_front());
                if (f[256]) begin
                    occ[d]--;
                    m_cnt[d] = m_cnt[d] + 32'd1;
                end
            end
            if (wr) begin
                if (m_full_n[d]) begin
                    pkt = cur_pkt();
                    if (d == 0) begin
                        bq0.push_back({1'b1, pkt});
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            bq1.push_back({(i == 3), 192'd0, pkt[255-64*i -: 64]});
                        end
                    end
                    occ[d]++;
                end else begin
                    m_ovf[d] = 1'b1;
                end
            end
            m_full_n[d] = (occ[d] < 2);
        end
    endtask

    // Inputs are already driven for this cycle; score both instances, then move to the next cycle.
    task automatic cycle();
        #1;
        score(0, wr_en1, din1, last1, full_n1, ovf1, cnt1);
        score(1, wr_en4, {192'd0, din4}, last4, full_n4, ovf4, cnt4);
        @(negedge ap_clk);
    endtask

    task automatic rand_fields();
        bs   = 8'($urandom);
        fpga = 8'($urandom);
        pckg = 16'($urandom);
        tx   = 8'($urandom);
        rx   = 8'($urandom);
        vpb  = 16'($urandom);
        for (int i = 0; i < 6; i++) begin
            msg[32*i +: 32] = $urandom;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            wr = 1'b0;
            cycle();
        end
    endtask

    initial begin
        int          pulses;
        logic        fn_drop;
        logic [31:0] cnt_start;

        ap_rst = 1'b1; wr = 1'b0; full = 1'b0;
        bs = '0; fpga = '0; pckg = '0; tx = '0; rx = '0; vpb = '0; msg = '0;
        model_reset();
        @(negedge ap_clk);

        // Reset state held for two cycles, then release
        cycle();
        cycle();
        ap_rst = 1'b0;
        cycle();

        // Single packet: BS_ID=A5, MESSAGE_0=11111111
        rand_fields();
        bs = 8'hA5;
        msg[191:160] = 32'h1111_1111;
        wr = 1'b1;
        cycle();
        wr = 1'b0;
        #1;
        chk("t1 b1 wr_en next cycle", 256'(wr_en1), 256'd1);
        chk("t1 b1 BS_ID byte", 256'(din1[255:248]), 256'hA5);
        chk("t1 b1 MESSAGE_0", 256'(din1[191:160]), 256'h1111_1111);
        chk("t1 b1 din_last", 256'(last1), 256'd1);
        chk("t1 b4 beat0 BS_ID", 256'(din4[63:56]), 256'hA5);
        cycle();
        #1;
        chk("t1 b1 pkt_count", 256'(cnt1), 256'd1);
        idle(6);

        // Backpressure: full held, then three back-to-back writes
        full = 1'b1;
        idle(10);
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            wr = 1'b1;
            cycle();
        end
        wr = 1'b0;
        #1;
        chk("bp b1 full_n after 2 accepted", 256'(full_n1), 256'd0);
        chk("bp b1 overflow on 3rd write", 256'(ovf1), 256'd1);
        chk("bp b1 wr_en held while full", 256'(wr_en1), 256'd0);
        idle(2);
        full = 1'b0;
        idle(12);

        // Sustained single-beat writes for 100 cycles
        pulses    = 0;
        fn_drop   = 1'b0;
        cnt_start = m_cnt[0];
        for (int i = 0; i < 101; i++) begin
            wr = (i < 100);
            rand_fields();
            #1;
            if (wr_en1) pulses++;
            if (!full_n1) fn_drop = 1'b1;
            cycle();
        end
        wr = 1'b0;
        #1;
        chk("sustain b1 wr_en pulses", 256'(pulses), 256'd100);
        chk("sustain b1 full_n dropped", 256'(fn_drop), 256'd0);
        chk("sustain b1 pkt_count", 256'(cnt1), 256'(cnt_start + 32'd100));
        idle(12);

        // Reset during beat 2 of a four-beat packet
        rand_fields();
        wr = 1'b1;
        cycle();
        wr = 1'b0;
        cycle();
        cycle();
        ap_rst = 1'b1;
        cycle();
        #1;
        chk("rst b4 wr_en zero", 256'(wr_en4), 256'd0);
        chk("rst b4 din zero", 256'(din4), 256'd0);
        chk("rst b4 full_n low", 256'(full_n4), 256'd0);
        cycle();
        ap_rst = 1'b0;
        cycle();
        #1;
        chk("rst b4 full_n after release", 256'(full_n4), 256'd1);
        chk("rst b4 pkt_count cleared", 256'(cnt4), 256'd0);
        rand_fields();
        wr = 1'b1;
        cycle();
        wr = 1'b0;
        #1;
        chk("rst b4 new packet beat0", 256'(din4), 256'(cur_pkt() >> 192));
        idle(6);

        // pkt_count wrap from all-ones
        force u_b1.pkt_count_q = 32'hFFFF_FFFF;
        release u_b1.pkt_count_q;
        m_cnt[0] = 32'hFFFF_FFFF;
        rand_fields();
        wr = 1'b1;
        cycle();
        wr = 1'b0;
        cycle();
        #1;
        chk("wrap b1 pkt_count", 256'(cnt1), 256'd0);
        idle(6);

        // Randomised traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            rand_fields();
            wr   = 1'($urandom_range(0, 1));
            full = ($urandom_range(0, 3) == 0);
            cycle();
        end
        wr   = 1'b0;
        full = 1'b0;
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
